mem_bus_initiator: RTL

MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

---
 rtl/bus2_pkg.sv | 27 ++
 rtl/mem_bus_initiator_if.sv | 26 ++
 rtl/bus2_line_serdes.sv | 60 ++++++
 rtl/mem_bus_initiator.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bus2_pkg.sv
// Shared definitions for the bus2 line initiator: command encodings,
// default bus widths and the transaction FSM state type.
package bus2_pkg;

    localparam int unsigned ADDR2_W_DEF     = 15;
    localparam int unsigned DATA2_W_DEF     = 16;
    localparam int unsigned CTR2_W_DEF      = 2;
    localparam int unsigned LINE_BYTES_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF     = 256;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        TURN,
        WAIT,
        RDATA,
        FIN
    } state_e;

endpackage

// File: rtl/mem_bus_initiator_if.sv
// Link between the initiator FSM (master) and the line serializer /
// deserializer (slave).
interface mem_bus_initiator_if #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned DATA_W = 16
);
    logic              load;
    logic [LINE_W-1:0] wr_line;
    logic              tx_step;
    logic              rx_cap;
    logic [DATA_W-1:0] rx_beat;
    logic [DATA_W-1:0] tx_beat;
    logic              first_beat;
    logic              last_beat;
    logic [LINE_W-1:0] rd_line;

    modport master (
        output load, wr_line, tx_step, rx_cap, rx_beat,
        input  tx_beat, first_beat, last_beat, rd_line
    );

    modport slave (
        input  load, wr_line, tx_step, rx_cap, rx_beat,
        output tx_beat, first_beat, last_beat, rd_line
    );
endinterface

// File: rtl/bus2_line_serdes.sv
// Beat shift register: serializes the write line low word first, assembles
// the read line beat by beat, and tracks the shared beat index.
module bus2_line_serdes #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BEATS  = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_bus_initiator_if.slave lnk
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [LINE_W-1:0] tx_q, tx_d;
    logic [LINE_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              last;

    assign last           = (beat_q == CNT_W'(BEATS - 1));
    assign lnk.tx_beat    = tx_q[DATA_W-1:0];
    assign lnk.first_beat = (beat_q == '0);
    assign lnk.last_beat  = last;
    assign lnk.rd_line    = rd_q;

    // The index wraps after the last beat so a read starting after a write
    // always lands beat 0 in the low word.
    always_comb begin
        tx_d   = tx_q;
        rd_d   = rd_q;
        beat_d = beat_q;
        if (lnk.load) begin
            tx_d   = lnk.wr_line;
            beat_d = '0;
        end else if (lnk.tx_step) begin
            tx_d   = tx_q >> DATA_W;
            beat_d = last ? '0 : beat_q + 1'b1;
        end else if (lnk.rx_cap) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (beat_q == CNT_W'(k)) begin
                    rd_d[k*DATA_W +: DATA_W] = lnk.rx_beat;
                end
            end
            beat_d = last ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q   <= '0;
            rd_q   <= '0;
            beat_q <= '0;
        end else begin
            tx_q   <= tx_d;
            rd_q   <= rd_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/mem_bus_initiator.sv
// Line read/write initiator on a shared tri-state A2/D2/C2 memory bus:
// command phase, one turnaround cycle, bounded wait for RESPONSE, data beats.
module mem_bus_initiator
    import bus2_pkg::*;
#(
    parameter int unsigned ADDR2_BUS_SIZE = ADDR2_W_DEF,
    parameter int unsigned DATA2_BUS_SIZE = DATA2_W_DEF,
    parameter int unsigned CTR2_BUS_SIZE  = CTR2_W_DEF,
    parameter int unsigned LINE_BYTES     = LINE_BYTES_DEF,
    parameter int unsigned TIMEOUT        = TIMEOUT_DEF
) (
    input  logic                        CLK,
    input  logic                        RESET,
    inout  wire logic [ADDR2_BUS_SIZE-1:0] A2_WIRE,
    inout  wire logic [DATA2_BUS_SIZE-1:0] D2_WIRE,
    inout  wire logic [CTR2_BUS_SIZE-1:0]  C2_WIRE,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR2_BUS_SIZE-1:0]   req_addr,
    input  logic [LINE_BYTES*8-1:0]     wr_line,
    output logic [LINE_BYTES*8-1:0]     rd_line,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned BEATS  = LINE_W / DATA2_BUS_SIZE;
    localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                    state_q, state_d;
    logic                      live_q;
    logic                      write_q, write_d;
    logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]          wcnt_q, wcnt_d;
    logic                      err_q, err_d;

    logic [CTR2_BUS_SIZE-1:0]  c2_out;
    logic                      c2_oe, a2_oe, d2_oe;
    logic                      c2_resp;

    mem_bus_initiator_if #(.LINE_W(LINE_W), .DATA_W(DATA2_BUS_SIZE)) lnk ();

    bus2_line_serdes #(
        .LINE_W (LINE_W),
        .DATA_W (DATA2_BUS_SIZE),
        .BEATS  (BEATS)
    ) u_serdes (
        .clk_i (CLK),
        .rst_i (RESET),
        .lnk   (lnk)
    );

    assign lnk.wr_line = wr_line;
    assign lnk.rx_beat = D2_WIRE;

    // X/Z on C2 compares unknown and therefore never counts as RESPONSE.
    assign c2_resp = (C2_WIRE == CTR2_BUS_SIZE'(C2_RESPONSE));

    assign C2_WIRE = c2_oe ? c2_out      : 'z;
    assign A2_WIRE = a2_oe ? addr_q      : 'z;
    assign D2_WIRE = d2_oe ? lnk.tx_beat : 'z;

    assign req_ready = live_q && (state_q == IDLE);
    assign done      = (state_q == FIN);
    assign err       = err_q;
    assign rd_line   = lnk.rd_line;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wcnt_d      = wcnt_q;
        err_d       = 1'b0;
        lnk.load    = 1'b0;
        lnk.tx_step = 1'b0;
        lnk.rx_cap  = 1'b0;
        c2_oe       = 1'b0;
        a2_oe       = 1'b0;
        d2_oe       = 1'b0;
        c2_out      = CTR2_BUS_SIZE'(C2_NOP);

        case (state_q)
            IDLE: begin
                // live_q keeps C2 released until the first clock after reset.
                c2_oe = live_q;
                if (req_valid && live_q) begin
                    write_d  = req_write;
                    addr_d   = req_addr;
                    lnk.load = 1'b1;
                    state_d  = CMD;
                end
            end
            CMD: begin
                c2_oe = 1'b1;
                if (write_q) begin
                    c2_out      = CTR2_BUS_SIZE'(C2_WRITE_LINE);
                    a2_oe       = lnk.first_beat;
                    d2_oe       = 1'b1;
                    lnk.tx_step = 1'b1;
                    if (lnk.last_beat) begin
                        state_d = TURN;
                    end
                end else begin
                    c2_out  = CTR2_BUS_SIZE'(C2_READ_LINE);
                    a2_oe   = 1'b1;
                    state_d = TURN;
                end
            end
            TURN: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (c2_resp) begin
                    if (write_q) begin
                        state_d = FIN;
                    end else begin
                        lnk.rx_cap = 1'b1;
                        state_d    = lnk.last_beat ? FIN : RDATA;
                    end
                end else if (wcnt_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RDATA: begin
                lnk.rx_cap = 1'b1;
                if (lnk.last_beat) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                c2_oe   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            write_q <= write_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

endmodule
